// File: rtl/rotsq_pkg.sv
// Shared types and defaults for the rotating-square button control stage.
// Debounce state encoding and the production debounce interval.
package rotsq_pkg;

    typedef enum logic [1:0] {
        IDLE_LO,
        WAIT_HI,
        IDLE_HI,
        WAIT_LO
    } db_state_t;

    // 10 ms at 100 MHz
    localparam int unsigned DB_TICKS_DEF = 1_000_000;

endpackage

// File: rtl/debounce_fsm.sv
// Two-flop synchroniser plus debounce FSM for one raw pushbutton.
// Emits a single-cycle press pulse per accepted press.
module debounce_fsm
    import rotsq_pkg::*;
#(
    parameter int unsigned DB_TICKS = DB_TICKS_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam int CW = $clog2(DB_TICKS);
    localparam logic [CW-1:0] LAST = CW'(DB_TICKS - 1);

    logic [1:0]    sync_q;
    logic          s;
    db_state_t     state_q;
    db_state_t     state_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign s = sync_q[1];

    // Bring the asynchronous button into the clock domain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], raw};
        end
    end

    // Debounce state and stability counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE_LO;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state; press fires on the cycle a high input is accepted.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        press   = 1'b0;
        unique case (state_q)
            IDLE_LO: begin
                if (s) begin
                    state_d = WAIT_HI;
                    cnt_d   = '0;
                end
            end
            WAIT_HI: begin
                if (!s) begin
                    state_d = IDLE_LO;
                end else if (cnt_q == LAST) begin
                    state_d = IDLE_HI;
                    press   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            IDLE_HI: begin
                if (!s) begin
                    state_d = WAIT_LO;
                    cnt_d   = '0;
                end
            end
            WAIT_LO: begin
                if (s) begin
                    state_d = IDLE_HI;
                end else if (cnt_q == LAST) begin
                    state_d = IDLE_LO;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE_LO;
                cnt_d   = '0;
            end
        endcase
    end

    // Debounced button level: high once a press has been accepted.
    assign level = (state_q == IDLE_HI) || (state_q == WAIT_LO);

endmodule

// File: rtl/rotsq_button_ctrl.sv
// Button control stage for the rotating-square display driver.
// Debounced presses toggle the en and cw levels.
module rotsq_button_ctrl
    import rotsq_pkg::*;
#(
    parameter int unsigned DB_TICKS = DB_TICKS_DEF,
    parameter logic        EN_RST   = 1'b0,
    parameter logic        CW_RST   = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_en,
    input  logic btn_dir,
    output logic en,
    output logic cw
);

    logic press_en;
    logic press_dir;
    logic en_q;
    logic cw_q;

    debounce_fsm #(.DB_TICKS(DB_TICKS)) u_db_en (
        .clk   (clk),
        .rst   (rst),
        .raw   (btn_en),
        .level (),
        .press (press_en)
    );

    debounce_fsm #(.DB_TICKS(DB_TICKS)) u_db_dir (
        .clk   (clk),
        .rst   (rst),
        .raw   (btn_dir),
        .level (),
        .press (press_dir)
    );

    // Each accepted press flips its level; buttons are independent.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_q <= EN_RST;
            cw_q <= CW_RST;
        end else begin
            if (press_en) begin
                en_q <= ~en_q;
            end
            if (press_dir) begin
                cw_q <= ~cw_q;
            end
        end
    end

    assign en = en_q;
    assign cw = cw_q;

endmodule

// File: tb/tb_rotsq_button_ctrl.sv
// Directed bench for rotsq_button_ctrl with a short debounce interval.
// Edge 0 is the first rising edge that samples a new button level.
module tb_rotsq_button_ctrl;

    logic clk;
    logic rst;
    logic btn_en;
    logic btn_dir;
    logic en;
    logic cw;

    int n_checks;
    int n_fails;

    rotsq_button_ctrl #(
        .DB_TICKS (4),
        .EN_RST   (1'b0),
        .CW_RST   (1'b1)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .btn_en  (btn_en),
        .btn_dir (btn_dir),
        .en      (en),
        .cw      (cw)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Run n edges numbered from 0; report toggle counts and first toggle edge.
    task automatic run_edges(
        input  int n,
        output int en_tog,
        output int en_at,
        output int cw_tog,
        output int cw_at
    );
        logic pe;
        logic pc;
        en_tog = 0;
        cw_tog = 0;
        en_at  = -1;
        cw_at  = -1;
        pe = en;
        pc = cw;
        for (int i = 0; i < n; i++) begin
            tick();
            if (en !== pe) begin
                en_tog++;
                if (en_at < 0) en_at = i;
            end
            if (cw !== pc) begin
                cw_tog++;
                if (cw_at < 0) cw_at = i;
            end
            pe = en;
            pc = cw;
        end
    endtask

    int et, ea, ct, ca;

    initial begin
        n_checks = 0;
        n_fails  = 0;
        btn_en   = 1'b0;
        btn_dir  = 1'b0;
        rst      = 1'b0;

        // 1: asynchronous reset and hold after release
        #2;
        rst = 1'b1;
        #1;
        check("rst_en_async", int'(en), 0);
        check("rst_cw_async", int'(cw), 1);
        tick();
        tick();
        #2;
        rst = 1'b0;
        run_edges(20, et, ea, ct, ca);
        check("rst_hold_en_tog", et, 0);
        check("rst_hold_cw_tog", ct, 0);
        check("rst_hold_en", int'(en), 0);
        check("rst_hold_cw", int'(cw), 1);

        // 2: clean press of btn_en
        btn_en = 1'b1;
        run_edges(10, et, ea, ct, ca);
        check("clean_en_tog", et, 1);
        check("clean_en_edge", ea, 6);
        check("clean_en_val", int'(en), 1);
        check("clean_cw_tog", ct, 0);
        btn_en = 1'b0;
        run_edges(10, et, ea, ct, ca);
        check("clean_release_tog", et, 0);

        // 3: bounce then steady press
        btn_en = 1'b1;
        run_edges(3, et, ea, ct, ca);
        check("bounce_early_tog", et, 0);
        btn_en = 1'b0;
        run_edges(1, et, ea, ct, ca);
        check("bounce_gap_tog", et, 0);
        btn_en = 1'b1;
        run_edges(10, et, ea, ct, ca);
        check("bounce_en_tog", et, 1);
        check("bounce_en_edge", ea, 6);
        check("bounce_en_val", int'(en), 0);
        btn_en = 1'b0;
        run_edges(10, et, ea, ct, ca);
        check("bounce_release_tog", et, 0);

        // 4: long hold, release, second press of btn_dir
        btn_dir = 1'b1;
        run_edges(50, et, ea, ct, ca);
        check("hold_cw_tog", ct, 1);
        check("hold_cw_edge", ca, 6);
        check("hold_cw_val", int'(cw), 0);
        check("hold_en_tog", et, 0);
        btn_dir = 1'b0;
        run_edges(10, et, ea, ct, ca);
        check("hold_release_tog", ct, 0);
        btn_dir = 1'b1;
        run_edges(10, et, ea, ct, ca);
        check("repress_cw_tog", ct, 1);
        check("repress_cw_edge", ca, 6);
        check("repress_cw_val", int'(cw), 1);
        btn_dir = 1'b0;
        run_edges(10, et, ea, ct, ca);
        check("repress_release_tog", ct, 0);

        // 5: simultaneous presses
        btn_en  = 1'b1;
        btn_dir = 1'b1;
        run_edges(10, et, ea, ct, ca);
        check("simul_en_tog", et, 1);
        check("simul_cw_tog", ct, 1);
        check("simul_en_edge", ea, 6);
        check("simul_cw_edge", ca, 6);
        check("simul_en_val", int'(en), 1);
        check("simul_cw_val", int'(cw), 0);
        btn_en  = 1'b0;
        btn_dir = 1'b0;
        run_edges(10, et, ea, ct, ca);
        check("simul_release_en_tog", et, 0);
        check("simul_release_cw_tog", ct, 0);

        // 6: reset abandons a debounce in progress
        btn_en = 1'b1;
        run_edges(3, et, ea, ct, ca);
        check("midrst_pre_tog", et, 0);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_en_async", int'(en), 0);
        check("midrst_cw_async", int'(cw), 1);
        tick();
        tick();
        check("midrst_en_held", int'(en), 0);
        #2;
        rst = 1'b0;
        run_edges(12, et, ea, ct, ca);
        check("midrst_en_tog", et, 1);
        check("midrst_en_edge", ea, 6);
        check("midrst_en_val", int'(en), 1);
        check("midrst_cw_tog", ct, 0);
        btn_en = 1'b0;
        run_edges(10, et, ea, ct, ca);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fails);
        $finish;
    end

endmodule
